// File: rtl/spin_pkg.sv
// rtl/spin_pkg.sv - shared state, LFSR and energy-class definitions for spin_sweep
package spin_pkg;

  typedef enum logic [1:0] {IDLE, EVEN, ODD, FIN} state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Energy change of flipping a site, keyed by how many neighbours agree with it.
  typedef enum logic [1:0] {DE_DOWN, DE_P4, DE_P8} de_class_e;

  function automatic de_class_e de_class(input logic [2:0] aligned);
    if (aligned == 3'd4) return DE_P8;
    if (aligned == 3'd3) return DE_P4;
    return DE_DOWN;
  endfunction

endpackage

// File: rtl/spin_lfsr32.sv
// rtl/spin_lfsr32.sv - 32-bit Galois LFSR with seed load and per-visit advance
module spin_lfsr32
  import spin_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  logic [31:0] lfsr_q, lfsr_d;

  // An all-zero state would lock up, so a zero seed is promoted to 1.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 32'd0) ? 32'd1 : seed;
    end else if (advance) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 32'd1;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/spin_sweep.sv
// rtl/spin_sweep.sv - checkerboard Metropolis sweep engine over a periodic 2D Ising lattice
module spin_sweep
  import spin_pkg::*;
#(
  parameter int W      = 8,
  parameter int H      = 8,
  parameter int RAND_W = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [15:0]                   num_sweeps,
  input  logic                          seed_load,
  input  logic [31:0]                   seed,
  input  logic                          init_up,
  input  logic [RAND_W:0]               thr4,
  input  logic [RAND_W:0]               thr8,
  input  logic [$clog2(W*H)-1:0]        rd_addr,
  output logic                          rd_spin,
  output logic                          busy,
  output logic                          done,
  output logic signed [$clog2(W*H)+1:0] mag,
  output logic [31:0]                   flips
);

  localparam int N  = W * H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(W);
  localparam int YW = AW - XW;
  localparam int MW = AW + 2;
  localparam logic signed [MW-1:0] MAG_FULL = MW'(N);
  localparam logic signed [MW-1:0] MAG_STEP = MW'(2);
  localparam logic [XW-1:0] X_ONE = 1;
  localparam logic [YW-1:0] Y_ONE = 1;
  localparam logic [AW-2:0] K_ONE = 1;

  state_e               state_q, state_d;
  logic [N-1:0]         spin_q, spin_d;
  logic signed [MW-1:0] mag_q, mag_d;
  logic [31:0]          flips_q, flips_d;
  logic [15:0]          sweeps_q, sweeps_d;
  logic [AW-2:0]        k_q, k_d;
  logic [RAND_W:0]      thr4_q, thr4_d, thr8_q, thr8_d;

  logic [31:0]   lfsr_val;
  logic          lfsr_load;
  logic          visiting;
  logic          unused_lfsr_low;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] site;
  logic          cur;
  logic [2:0]    aligned;
  logic [RAND_W:0] rnd;
  logic          accept;

  spin_lfsr32 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (seed),
    .advance (visiting),
    .value   (lfsr_val)
  );

  assign visiting = (state_q == EVEN) || (state_q == ODD);

  // k counts same-colour sites; the colour bit is the column LSB, so raster order is kept.
  assign y    = k_q[AW-2:XW-1];
  assign x    = {k_q[XW-2:0], y[0] ^ (state_q == ODD)};
  assign site = {y, x};
  assign cur  = spin_q[site];

  assign aligned = {2'b00, spin_q[{y, x + X_ONE}] == cur}
                 + {2'b00, spin_q[{y, x - X_ONE}] == cur}
                 + {2'b00, spin_q[{y + Y_ONE, x}] == cur}
                 + {2'b00, spin_q[{y - Y_ONE, x}] == cur};

  assign rnd             = {1'b0, lfsr_val[31 -: RAND_W]};
  assign unused_lfsr_low = ^lfsr_val[31-RAND_W:0];

  always_comb begin
    accept = 1'b1;
    case (de_class(aligned))
      DE_P8:   accept = rnd < thr8_q;
      DE_P4:   accept = rnd < thr4_q;
      default: accept = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    spin_d    = spin_q;
    mag_d     = mag_q;
    flips_d   = flips_q;
    sweeps_d  = sweeps_q;
    k_d       = k_q;
    thr4_d    = thr4_q;
    thr8_d    = thr8_q;
    lfsr_load = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        lfsr_load = seed_load;
        if (init_up) begin
          spin_d = '1;
          mag_d  = MAG_FULL;
        end
        if (start) begin
          sweeps_d = num_sweeps;
          thr4_d   = thr4;
          thr8_d   = thr8;
          k_d      = '0;
          state_d  = (num_sweeps == 16'd0) ? FIN : EVEN;
        end
      end
      EVEN, ODD: begin
        if (accept) begin
          spin_d[site] = ~cur;
          mag_d        = cur ? (mag_q - MAG_STEP) : (mag_q + MAG_STEP);
          flips_d      = flips_q + 32'd1;
        end
        k_d = k_q + K_ONE;
        if (&k_q) begin
          if (state_q == EVEN) begin
            state_d = ODD;
          end else begin
            sweeps_d = sweeps_q - 16'd1;
            state_d  = (sweeps_q == 16'd1) ? FIN : EVEN;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      spin_q   <= '1;
      mag_q    <= MAG_FULL;
      flips_q  <= 32'd0;
      sweeps_q <= 16'd0;
      k_q      <= '0;
      thr4_q   <= '0;
      thr8_q   <= '0;
    end else begin
      state_q  <= state_d;
      spin_q   <= spin_d;
      mag_q    <= mag_d;
      flips_q  <= flips_d;
      sweeps_q <= sweeps_d;
      k_q      <= k_d;
      thr4_q   <= thr4_d;
      thr8_q   <= thr8_d;
    end
  end

  assign busy    = visiting;
  assign rd_spin = spin_q[rd_addr];
  assign mag     = mag_q;
  assign flips   = flips_q;

endmodule

// File: doc/spin_sweep.md
SPIN_SWEEP -- requirements
Module: spin_sweep

Interface
REQ-001 SHALL have parameter W, default 8, meaning lattice width in sites (power of 2, >=4).
REQ-002 SHALL have parameter H, default 8, meaning lattice height in sites (power of 2, >=4).
REQ-003 SHALL have parameter RAND_W, default 12, meaning random/threshold compare width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  single-cycle request to run num_sweeps sweeps; honoured only in IDLE.
REQ-007 num_sweeps  in  16  sweep count, sampled with start.
REQ-008 seed_load  in  1  loads seed into LFSR; honoured only in IDLE.
REQ-009 seed  in  32  LFSR seed.
REQ-010 init_up  in  1  sets every spin to +1; honoured only in IDLE.
REQ-011 thr4  in  RAND_W+1  acceptance threshold for dE=+4J, sampled with start.
REQ-012 thr8  in  RAND_W+1  acceptance threshold for dE=+8J, sampled with start.
REQ-013 rd_addr  in  log2(W*H)  site index y*W+x for read port.
REQ-014 rd_spin  out  1  combinational spin at rd_addr (1=+1, 0=-1).
REQ-015 busy  out  1  high from cycle after start accepted until done.
REQ-016 done  out  1  one-cycle pulse at completion.
REQ-017 mag  out  log2(W*H)+2  signed sum of spins.
REQ-018 flips  out  32  total accepted flips since reset, wraps modulo 2^32.

Function
REQ-019 FSM SHALL have states IDLE, EVEN, ODD, FIN; IDLE->EVEN on start with num_sweeps>0; IDLE->FIN on start with num_sweeps=0; EVEN->ODD after last even site; ODD->EVEN if sweeps remain, else ODD->FIN; FIN->IDLE unconditionally.
REQ-020 EVEN visits sites with (x+y) even, ODD sites with (x+y) odd, raster order (y outer, x inner), one site per cycle; one sweep = W*H cycles.
REQ-021 Neighbours SHALL use periodic boundaries (index wrap modulo W and H).
REQ-022 With a = neighbours equal to current spin (0..4), dE = (4a-8)J; flip SHALL be accepted if a<=2, else if rnd < thr4 (a=3) or rnd < thr8 (a=4), rnd = LFSR[31:32-RAND_W] of that cycle.
REQ-023 Threshold value 2^RAND_W SHALL mean always accept; 0 never accept.
REQ-024 Spin update, mag (+-2) and flips (+1) SHALL commit on the same edge as the visit.
REQ-025 LFSR SHALL be 32-bit Galois, taps 0x80200003, advancing once per visited site only; seed 0 SHALL load as 1.
REQ-026 done SHALL assert in FIN, exactly num_sweeps*W*H+1 cycles after the start edge; busy low in IDLE and FIN.
REQ-027 start, seed_load, init_up outside IDLE SHALL be ignored; if asserted together in IDLE, priority seed_load and init_up applied, start also accepted with the new seed and spins.
REQ-028 init_up SHALL set mag to W*H.

Reset
REQ-029 On rst: state IDLE, all spins +1, mag=W*H, flips=0, LFSR=1, busy=0, done=0, sweep counter 0; rst mid-sweep SHALL abort with no done pulse.

Structure
REQ-030 Package spin_pkg SHALL hold the state enum, LFSR tap constant and dE class encoding.
REQ-031 Sub-module spin_lfsr32 SHALL implement the LFSR (load, advance, value).
REQ-032 Lattice SHALL be a W*H flop array; no RAM inference required.

Verification (W=H=4, RAND_W=12)
REQ-033 Reset -> all rd_spin=1, mag=16, flips=0, busy=0.
REQ-034 thr4=thr8=0, start num_sweeps=1 -> no flips, done exactly 17 cycles after start, mag=16.
REQ-035 thr8=4096, thr4=4096, start num_sweeps=1 from all-up -> all 8 even then all 8 odd flip, mag=-16, flips=16.
REQ-036 start num_sweeps=0 -> done next cycle, spins, mag, LFSR unchanged.
REQ-037 seed_load and start asserted during EVEN -> ignored, sweep count and LFSR sequence unchanged versus reference model.
REQ-038 rst asserted mid-sweep with seed 0xACE1 -> immediate all-up, mag=16, no done; rerun matches model bit-exact.
